model_buffer: RTL and testbench

- Responder for the transform pipeline's model-buffer read interfaces.
- Holds vertex and index memories plus a model descriptor table, loaded by the host/loader.
- On start, latches one model's descriptor and serves vertex and index streams element by element on read-enable pulses.
- Each returned element carries dv and last flags.

---
 rtl/model_buffer_pkg.sv | 36 +++
 rtl/model_buffer_if.sv | 31 +++
 rtl/model_buffer_stream.sv | 73 +++++++
 rtl/model_buffer.sv | 145 ++++++++++++++
 tb/tb_model_buffer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/model_buffer_pkg.sv
// model_buffer_pkg
//   Shared types and sizing for the model buffer. Memory depths, the
//   vertex component width and the model count are set here; every derived
//   width used by the interface, top level and testbench comes from here.
//   No ports.
package model_buffer_pkg;

    localparam int DATAWIDTH          = 24;   // Q10.13 signed vertex component
    localparam int FRACBITS           = 13;
    localparam int MAX_VERTEX_COUNT   = 4096;
    localparam int MAX_TRIANGLE_COUNT = 4096;
    localparam int MAX_MODEL_COUNT    = 16;

    localparam int VA_W  = $clog2(MAX_VERTEX_COUNT);    // vertex address / index value
    localparam int TA_W  = $clog2(MAX_TRIANGLE_COUNT);  // triangle address
    localparam int MID_W = $clog2(MAX_MODEL_COUNT);

    // Three components per vertex / three indices per triangle, element 0 in the LSBs.
    // Vertex components are two's complement; the packed vector is treated as raw bits.
    typedef logic [2:0][DATAWIDTH-1:0] vertex_t;
    typedef logic [2:0][VA_W-1:0]      tri_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [VA_W-1:0] vtx_base;
        logic [VA_W:0]   vtx_count;
        logic [TA_W-1:0] idx_base;
        logic [TA_W:0]   idx_count;
    } model_desc_t;

endpackage

// File: rtl/model_buffer_if.sv
// model_buffer_if
//   Read side of the model buffer as seen by the transform pipeline.
//   slave  : model_buffer (drives data/dv/last, receives read enables)
//   master : pipeline (drives read enables)
//   Signals: i_vertex_read_en, o_vertex, o_vertex_dv, o_vertex_last,
//            i_index_read_en,  o_index,  o_index_dv,  o_index_last
interface model_buffer_if;
    import model_buffer_pkg::*;

    logic    i_vertex_read_en;
    vertex_t o_vertex;
    logic    o_vertex_dv;
    logic    o_vertex_last;

    logic    i_index_read_en;
    tri_t    o_index;
    logic    o_index_dv;
    logic    o_index_last;

    modport slave (
        input  i_vertex_read_en, i_index_read_en,
        output o_vertex, o_vertex_dv, o_vertex_last,
        output o_index, o_index_dv, o_index_last
    );

    modport master (
        output i_vertex_read_en, i_index_read_en,
        input  o_vertex, o_vertex_dv, o_vertex_last,
        input  o_index, o_index_dv, o_index_last
    );
endinterface

// File: rtl/model_buffer_stream.sv
// model_buffer_stream
//   One read-stream engine: a single-write/single-read registered memory plus
//   pointer/remaining counters. A read enable with remaining != 0 returns the
//   word at ptr one cycle later with dv (and last when it was the final word).
//   Ports: clk, rstn (sync, active low); we_i/waddr_i/wdata_i loader write;
//   load_i/base_i/count_i latch a new stream; rd_en_i request;
//   data_o/dv_o/last_o response; idle_o = exhausted with nothing in flight.
module model_buffer_stream #(
    parameter int  W     = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   count_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  data_o,
    output logic          dv_o,
    output logic          last_o,
    output logic          idle_o
);
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  data_q;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic          dv_q, last_q, fire;

    assign fire = rd_en_i && (rem_q != '0) && !load_i;

    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        if (load_i) begin
            ptr_d = base_i;
            rem_d = count_i;
        end else if (fire) begin
            // explicit wrap keeps non-power-of-two depths correct
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            rem_d = rem_q - 1'b1;
        end
    end

    // Contents survive reset; the read below sees the pre-write value (read-first).
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q  <= '0;
            rem_q  <= '0;
            dv_q   <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            rem_q  <= rem_d;
            dv_q   <= fire;
            last_q <= fire && (rem_q == (AW+1)'(1));
            if (fire) data_q <= mem[ptr_q];   // data holds between reads
        end
    end

    assign data_o = data_q;
    assign dv_o   = dv_q;
    assign last_o = last_q;
    assign idle_o = (rem_q == '0) && !dv_q;
endmodule

// File: rtl/model_buffer.sv
// model_buffer
//   Model-buffer responder: vertex/index memories and a descriptor table
//   written by the loader; i_start latches one model and serves its vertex
//   and index streams on read-enable pulses (1-cycle latency, dv/last).
//   Ports: clk, rstn (sync, active low); i_vtx_*, i_idx_*, i_desc_* loader
//   writes (accepted in any state); i_start/i_model_id/o_ready/o_done control;
//   rd (model_buffer_if.slave) read streams.
//   Optional: MODEL_BUFFER_BOUNDS_CHECK_EN adds o_index_oob / o_oob_seen and
//   zeroes any index >= the model's vertex count.
module model_buffer
    import model_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_vtx_we,
    input  logic [VA_W-1:0]      i_vtx_waddr,
    input  vertex_t              i_vtx_wdata,
    input  logic                 i_idx_we,
    input  logic [TA_W-1:0]      i_idx_waddr,
    input  tri_t                 i_idx_wdata,
    input  logic                 i_desc_we,
    input  logic [MID_W-1:0]     i_desc_id,
    input  logic [VA_W-1:0]      i_desc_vtx_base,
    input  logic [VA_W:0]        i_desc_vtx_count,
    input  logic [TA_W-1:0]      i_desc_idx_base,
    input  logic [TA_W:0]        i_desc_idx_count,
    input  logic                 i_start,
    input  logic [MID_W-1:0]     i_model_id,
    output logic                 o_ready,
    output logic                 o_done,
    model_buffer_if.slave        rd
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
    ,
    output logic                 o_index_oob,
    output logic                 o_oob_seen
`endif
);
    state_t      state_q, state_d;
    model_desc_t desc_q [MAX_MODEL_COUNT];
    model_desc_t sel;
    logic        start_acc, vtx_idle, idx_idle;
    tri_t        idx_raw;

    assign sel       = desc_q[i_model_id];
    assign start_acc = (state_q == IDLE) && i_start;
    assign o_ready   = (state_q == IDLE);
    assign o_done    = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc)
                         state_d = (sel.vtx_count == '0 && sel.idx_count == '0) ? DONE : STREAM;
            STREAM:  if (vtx_idle && idx_idle) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            for (int m = 0; m < MAX_MODEL_COUNT; m++) desc_q[m] <= '0;
        end else begin
            state_q <= state_d;
            // the streams hold their own copy, so rewriting the active slot is harmless
            if (i_desc_we)
                desc_q[i_desc_id] <= '{vtx_base:  i_desc_vtx_base,  vtx_count: i_desc_vtx_count,
                                       idx_base:  i_desc_idx_base,  idx_count: i_desc_idx_count};
        end
    end

    model_buffer_stream #(.W(3*DATAWIDTH), .DEPTH(MAX_VERTEX_COUNT)) u_vtx (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (i_vtx_we),
        .waddr_i (i_vtx_waddr),
        .wdata_i (i_vtx_wdata),
        .load_i  (start_acc),
        .base_i  (sel.vtx_base),
        .count_i (sel.vtx_count),
        .rd_en_i (rd.i_vertex_read_en),
        .data_o  (rd.o_vertex),
        .dv_o    (rd.o_vertex_dv),
        .last_o  (rd.o_vertex_last),
        .idle_o  (vtx_idle)
    );

    model_buffer_stream #(.W(3*VA_W), .DEPTH(MAX_TRIANGLE_COUNT)) u_idx (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (i_idx_we),
        .waddr_i (i_idx_waddr),
        .wdata_i (i_idx_wdata),
        .load_i  (start_acc),
        .base_i  (sel.idx_base),
        .count_i (sel.idx_count),
        .rd_en_i (rd.i_index_read_en),
        .data_o  (idx_raw),
        .dv_o    (rd.o_index_dv),
        .last_o  (rd.o_index_last),
        .idle_o  (idx_idle)
    );

`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
    logic [VA_W:0] vcnt_q;
    tri_t          idx_fix, idx_hold_q;
    logic          oob, oob_seen_q;

    always_comb begin
        idx_fix = idx_raw;
        oob     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if ({1'b0, idx_raw[k]} >= vcnt_q) begin
                idx_fix[k] = '0;
                oob        = 1'b1;
            end
        end
    end

    // vcnt_q changes on the next start, so the held output is kept as already
    // corrected rather than re-masked against the new model's count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vcnt_q     <= '0;
            idx_hold_q <= '0;
            oob_seen_q <= 1'b0;
        end else begin
            if (start_acc) begin
                vcnt_q     <= sel.vtx_count;
                oob_seen_q <= 1'b0;
            end else if (o_index_oob) begin
                oob_seen_q <= 1'b1;
            end
            if (rd.o_index_dv) idx_hold_q <= idx_fix;
        end
    end

    assign rd.o_index  = rd.o_index_dv ? idx_fix : idx_hold_q;
    assign o_index_oob = rd.o_index_dv && oob;
    assign o_oob_seen  = oob_seen_q;
`else
    assign rd.o_index  = idx_raw;
`endif
endmodule

// File: tb/tb_model_buffer.sv
module tb_model_buffer;
    import model_buffer_pkg::*;

    localparam int VW = 3*DATAWIDTH;
    localparam int IW = 3*VA_W;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              i_vtx_we = 1'b0;
    logic [VA_W-1:0]   i_vtx_waddr = '0;
    vertex_t           i_vtx_wdata = '0;
    logic              i_idx_we = 1'b0;
    logic [TA_W-1:0]   i_idx_waddr = '0;
    tri_t              i_idx_wdata = '0;
    logic              i_desc_we = 1'b0;
    logic [MID_W-1:0]  i_desc_id = '0;
    logic [VA_W-1:0]   i_desc_vtx_base = '0;
    logic [VA_W:0]     i_desc_vtx_count = '0;
    logic [TA_W-1:0]   i_desc_idx_base = '0;
    logic [TA_W:0]     i_desc_idx_count = '0;
    logic              i_start = 1'b0;
    logic [MID_W-1:0]  i_model_id = '0;
    logic              o_ready, o_done;
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
    logic              o_index_oob, o_oob_seen;
`endif

    model_buffer_if rd();

    model_buffer dut (
        .clk(clk), .rstn(rstn),
        .i_vtx_we(i_vtx_we), .i_vtx_waddr(i_vtx_waddr), .i_vtx_wdata(i_vtx_wdata),
        .i_idx_we(i_idx_we), .i_idx_waddr(i_idx_waddr), .i_idx_wdata(i_idx_wdata),
        .i_desc_we(i_desc_we), .i_desc_id(i_desc_id),
        .i_desc_vtx_base(i_desc_vtx_base), .i_desc_vtx_count(i_desc_vtx_count),
        .i_desc_idx_base(i_desc_idx_base), .i_desc_idx_count(i_desc_idx_count),
        .i_start(i_start), .i_model_id(i_model_id),
        .o_ready(o_ready), .o_done(o_done),
        .rd(rd)
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
        , .o_index_oob(o_index_oob), .o_oob_seen(o_oob_seen)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference memories / descriptor table written alongside the DUT
    logic [VW-1:0] vmem [MAX_VERTEX_COUNT];
    logic [IW-1:0] imem [MAX_TRIANGLE_COUNT];
    model_desc_t   dmod [MAX_MODEL_COUNT];

    // scoreboard: {last, data} and {oob, last, data}
    logic [VW:0]   vq [$];
    logic [IW+1:0] iq [$];

    function automatic logic [VW-1:0] rnd_vtx();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[VW-1:0];
    endfunction

    function automatic logic [IW-1:0] tri3(input int a, input int b, input int c);
        return {VA_W'(c), VA_W'(b), VA_W'(a)};
    endfunction

    function automatic logic [IW+1:0] idx_exp(input logic [IW-1:0] t, input logic [VA_W:0] vc,
                                              input logic last);
        logic [IW-1:0] r;
        logic          oob;
        r   = t;
        oob = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if ({1'b0, t[k*VA_W +: VA_W]} >= vc) begin
                oob = 1'b1;
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
                r[k*VA_W +: VA_W] = '0;
`endif
            end
        end
        return {oob, last, r};
    endfunction

    // expected-dv: a read counts when issued with items still owed
    bit vexp = 1'b0, iexp = 1'b0, rstd = 1'b0;
    always @(posedge clk) begin
        vexp <= rstn && rd.i_vertex_read_en && (vq.size() > 0);
        iexp <= rstn && rd.i_index_read_en  && (iq.size() > 0);
        rstd <= !rstn;
    end

    int done_cnt = 0;
    always @(negedge clk) if (o_done) done_cnt <= done_cnt + 1;

    logic [VW:0]   ve;
    logic [IW+1:0] ie;
    logic [VW-1:0] vhold = '0;
    logic [IW-1:0] ihold = '0;
    always @(negedge clk) begin
        if (rstd) begin
            vhold = '0;
            ihold = '0;
        end
        chk("vertex_dv", rd.o_vertex_dv, vexp);
        if (rd.o_vertex_dv) begin
            if (vq.size() > 0) begin
                ve = vq.pop_front();
                chk("vertex_data", rd.o_vertex, ve[VW-1:0]);
                chk("vertex_last", rd.o_vertex_last, ve[VW]);
                vhold = ve[VW-1:0];
            end
        end else begin
            chk("vertex_hold", rd.o_vertex, vhold);
            chk("vertex_last_idle", rd.o_vertex_last, 1'b0);
        end
        chk("index_dv", rd.o_index_dv, iexp);
        if (rd.o_index_dv) begin
            if (iq.size() > 0) begin
                ie = iq.pop_front();
                chk("index_data", rd.o_index, ie[IW-1:0]);
                chk("index_last", rd.o_index_last, ie[IW]);
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
                chk("index_oob", o_index_oob, ie[IW+1]);
`endif
                ihold = ie[IW-1:0];
            end
        end else begin
            chk("index_hold", rd.o_index, ihold);
            chk("index_last_idle", rd.o_index_last, 1'b0);
        end
    end

    task automatic wr_vtx(input int a, input logic [VW-1:0] d);
        i_vtx_we = 1'b1; i_vtx_waddr = VA_W'(a); i_vtx_wdata = d;
        @(negedge clk);
        i_vtx_we = 1'b0;
        vmem[a] = d;
    endtask

    task automatic wr_idx(input int a, input logic [IW-1:0] d);
        i_idx_we = 1'b1; i_idx_waddr = TA_W'(a); i_idx_wdata = d;
        @(negedge clk);
        i_idx_we = 1'b0;
        imem[a] = d;
    endtask

    task automatic wr_desc(input int id, input int vb, input int vc, input int ib, input int ic);
        i_desc_we = 1'b1; i_desc_id = MID_W'(id);
        i_desc_vtx_base = VA_W'(vb); i_desc_vtx_count = (VA_W+1)'(vc);
        i_desc_idx_base = TA_W'(ib); i_desc_idx_count = (TA_W+1)'(ic);
        @(negedge clk);
        i_desc_we = 1'b0;
        dmod[id] = '{vtx_base: VA_W'(vb), vtx_count: (VA_W+1)'(vc),
                     idx_base: TA_W'(ib), idx_count: (TA_W+1)'(ic)};
    endtask

    // queue the model's expected streams, then pulse i_start (read enables low)
    task automatic start_model(input int id);
        model_desc_t d;
        d = dmod[id];
        for (int k = 0; k < int'(d.vtx_count); k++)
            vq.push_back({k == int'(d.vtx_count) - 1, vmem[(int'(d.vtx_base) + k) % MAX_VERTEX_COUNT]});
        for (int k = 0; k < int'(d.idx_count); k++)
            iq.push_back(idx_exp(imem[(int'(d.idx_base) + k) % MAX_TRIANGLE_COUNT], d.vtx_count,
                                 k == int'(d.idx_count) - 1));
        rd.i_vertex_read_en = 1'b0; rd.i_index_read_en = 1'b0;
        i_start = 1'b1; i_model_id = MID_W'(id);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // mode 0: read_en held high; mode 1: read_en every 3rd cycle
    task automatic run(input int mode, input string tag);
        int c, d0;
        c  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && c < 300) begin
            rd.i_vertex_read_en = (mode == 0) || (c % 3 == 0);
            rd.i_index_read_en  = (mode == 0) || (c % 3 == 0);
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, done_cnt - d0, 1);
        rd.i_vertex_read_en = 1'b1; rd.i_index_read_en = 1'b1;
        repeat (4) @(negedge clk);
        rd.i_vertex_read_en = 1'b0; rd.i_index_read_en = 1'b0;
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_vq_empty"}, vq.size(), 0);
        chk({tag, "_iq_empty"}, iq.size(), 0);
        chk({tag, "_ready"}, o_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd.i_vertex_read_en = 1'b0;
        rd.i_index_read_en  = 1'b0;
        for (int m = 0; m < MAX_MODEL_COUNT; m++) dmod[m] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_done", o_done, 1'b0);
        chk("rst_vertex", rd.o_vertex, '0);
        chk("rst_index", rd.o_index, '0);
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
        chk("rst_oob", o_index_oob, 1'b0);
        chk("rst_oob_seen", o_oob_seen, 1'b0);
`endif
        rstn = 1'b1;

        for (int a = 10; a < 15; a++) wr_vtx(a, rnd_vtx());
        wr_vtx(4094, rnd_vtx()); wr_vtx(4095, rnd_vtx());
        wr_vtx(0, rnd_vtx());    wr_vtx(1, rnd_vtx());
        for (int a = 20; a < 23; a++) wr_vtx(a, rnd_vtx());
        wr_idx(0, tri3(0, 1, 2)); wr_idx(1, tri3(2, 3, 4)); wr_idx(2, tri3(4, 0, 1));
        wr_idx(7, tri3(0, 1, 2)); wr_idx(8, tri3(3, 2, 1));
        wr_idx(9, tri3(0, 3, 1));
        wr_desc(2, 10, 5, 0, 3);
        wr_desc(3, 4094, 4, 7, 2);
        wr_desc(5, 0, 0, 0, 0);
        wr_desc(6, 20, 3, 9, 1);

        // model 2, held read_en; vertex 10 rewritten on the first read cycle (old data expected)
        start_model(2);
        chk("stream_not_ready", o_ready, 1'b0);
        rd.i_vertex_read_en = 1'b1; rd.i_index_read_en = 1'b1;
        i_vtx_we = 1'b1; i_vtx_waddr = VA_W'(10); i_vtx_wdata = rnd_vtx();
        @(negedge clk);
        i_vtx_we = 1'b0;
        vmem[10] = i_vtx_wdata;
        run(0, "held");

        // sparse reads, then read_en kept high past the end
        start_model(2);
        run(1, "sparse");

        // address wrap 4094, 4095, 0, 1
        start_model(3);
        run(0, "wrap");

        // both counts zero
        start_model(5);
        run(0, "zero");

        // start and descriptor rewrite while streaming are both ignored
        start_model(2);
        repeat (2) @(negedge clk);
        i_start = 1'b1; i_model_id = MID_W'(3);
        i_desc_we = 1'b1; i_desc_id = MID_W'(2);
        i_desc_vtx_base = '0; i_desc_vtx_count = (VA_W+1)'(1);
        i_desc_idx_base = '0; i_desc_idx_count = (TA_W+1)'(1);
        @(negedge clk);
        i_start = 1'b0; i_desc_we = 1'b0;
        dmod[2] = '{vtx_base: '0, vtx_count: (VA_W+1)'(1), idx_base: '0, idx_count: (TA_W+1)'(1)};
        chk("restart_not_ready", o_ready, 1'b0);
        run(0, "restart_ignored");

        // reset mid-stream
        start_model(3);
        rd.i_vertex_read_en = 1'b1; rd.i_index_read_en = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        vq.delete(); iq.delete();
        @(negedge clk);
        rstn = 1'b1;
        rd.i_vertex_read_en = 1'b0; rd.i_index_read_en = 1'b0;
        chk("midrst_ready", o_ready, 1'b1);
        chk("midrst_vdv", rd.o_vertex_dv, 1'b0);
        chk("midrst_idv", rd.o_index_dv, 1'b0);
        for (int m = 0; m < MAX_MODEL_COUNT; m++) dmod[m] = '0;

        // descriptor table cleared by reset: model 3 now has zero counts
        start_model(3);
        run(0, "desc_cleared");

        // memories survive reset
        wr_desc(3, 4094, 4, 7, 2);
        start_model(3);
        run(1, "retained");

        // model 6: triangle {0,3,1} against vertex count 3
        wr_desc(6, 20, 3, 9, 1);
        start_model(6);
        run(0, "bounds");
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
        chk("oob_seen_set", o_oob_seen, 1'b1);
`endif
        wr_desc(5, 0, 0, 0, 0);
        start_model(5);
`ifdef MODEL_BUFFER_BOUNDS_CHECK_EN
        chk("oob_seen_cleared", o_oob_seen, 1'b0);
`endif
        run(0, "zero2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
